// File: rtl/handshake_tx.sv
// handshake_tx: source side of a 4-phase req/ack handshake for clock-domain crossings.
// Define HS_TIMEOUT_EN to add the REQ-state timeout with a one-cycle `err` pulse.
module handshake_tx #(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data,
   input  logic             send,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             req_out,
   output logic [WIDTH-1:0] data_out,
   input  logic             ack_in
);

   typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] ack_sync_q;
   logic                   ack_s;
   logic                   req_d, busy_d, done_d;
   logic [WIDTH-1:0]       data_d;

   if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("handshake_tx: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
   end

   assign ack_s = ack_sync_q[SYNC_STAGES-1];

`ifdef HS_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q, tmo_d;
   logic             err_d;
`else
   assign err = 1'b0;
`endif

   // Next-state and next-output decode
   always_comb begin
      state_d = state_q;
      req_d   = req_out;
      data_d  = data_out;
      busy_d  = busy;
      done_d  = 1'b0;
`ifdef HS_TIMEOUT_EN
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      err_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (send) begin
               data_d  = data;
               req_d   = 1'b1;
               busy_d  = 1'b1;
               state_d = REQ;
`ifdef HS_TIMEOUT_EN
               cnt_d   = '0;
               tmo_d   = 1'b0;
`endif
            end
         end
         REQ: begin
            // A synchronized ack on the expiry edge takes priority over the timeout
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = RELEASE;
            end
`ifdef HS_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               tmo_d   = 1'b1;
               state_d = RELEASE;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
`endif
         end
         RELEASE: begin
            if (!ack_s) begin
               busy_d  = 1'b0;
               state_d = IDLE;
`ifdef HS_TIMEOUT_EN
               done_d  = ~tmo_q;
`else
               done_d  = 1'b1;
`endif
            end
         end
         default: begin
            req_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State, output and ack synchronizer registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         ack_sync_q <= '0;
         req_out    <= 1'b0;
         data_out   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
`ifdef HS_TIMEOUT_EN
         cnt_q      <= '0;
         tmo_q      <= 1'b0;
         err        <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_in};
         req_out    <= req_d;
         data_out   <= data_d;
         busy       <= busy_d;
         done       <= done_d;
`ifdef HS_TIMEOUT_EN
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
         err        <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_handshake_tx.sv
// tb_handshake_tx: scoreboard bench for handshake_tx with a delayed 4-phase responder model.
// Exercises the timeout path when HS_TIMEOUT_EN is defined.
module tb_handshake_tx;
   localparam int unsigned WIDTH    = 8;
   localparam int          S        = 2;
   localparam int          TMO      = 16;
   localparam int          RESP_DLY = 3;
   localparam int          LIMIT    = 200;

   logic             clk    = 1'b0;
   logic             reset  = 1'b1;
   logic [WIDTH-1:0] data   = '0;
   logic             send   = 1'b0;
   logic             ack_in = 1'b0;
   logic             busy, done, err, req_out;
   logic [WIDTH-1:0] data_out;

   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int rcnt     = 0;
   bit resp_en  = 1'b0;
   logic [WIDTH-1:0] exp_q[$];

   handshake_tx #(
      .WIDTH          (WIDTH),
      .SYNC_STAGES    (S),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .data     (data),
      .send     (send),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .req_out  (req_out),
      .data_out (data_out),
      .ack_in   (ack_in)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Responder: ack_in follows req_out RESP_DLY cycles later
   always @(posedge clk) begin
      #2;
      if (!resp_en) begin
         ack_in = 1'b0;
         rcnt   = 0;
      end else if (req_out !== ack_in) begin
         rcnt++;
         if (rcnt == RESP_DLY) begin
            ack_in = req_out;
            rcnt   = 0;
         end
      end else begin
         rcnt = 0;
      end
   end

   always @(posedge clk) begin
      #3;
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) err_cnt++;
   end

   task automatic wait_done(output int t, output bit ok);
      ok = 1'b0;
      t  = -1;
      for (int i = 0; i < LIMIT; i++) begin
         if (done === 1'b1) begin
            ok = 1'b1;
            t  = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      send  = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({req_out, busy, done, err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: req/busy/done/err=%b want 0000", {req_out, busy, done, err});
      end
      checks++;
      if (data_out !== '0) begin
         errors++;
         $display("FAIL reset_data: data_out=%h want 00", data_out);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({req_out, busy, done, err} !== 4'b0000) begin
         errors++;
         $display("FAIL idle_ctrl: req/busy/done/err=%b want 0000", {req_out, busy, done, err});
      end
   endtask

   task automatic test_handshake();
      int t_send, t_ack, t_fall, t_drop, t_done, d0;
      bit ok;
      logic [WIDTH-1:0] exp;
      resp_en = 1'b1;
      d0      = done_cnt;
      send    = 1'b1;
      data    = 8'hA5;
      exp_q.push_back(8'hA5);
      @(negedge clk);
      send   = 1'b0;
      data   = 8'h00;
      t_send = cyc;
      checks++;
      if (req_out !== 1'b1 || busy !== 1'b1 || data_out !== 8'hA5) begin
         errors++;
         $display("FAIL hs_accept: req=%b busy=%b data_out=%h want 1 1 a5", req_out, busy, data_out);
      end
      t_ack = -1;
      for (int i = 0; i < LIMIT; i++) begin
         if (ack_in === 1'b1) begin
            t_ack = cyc + 1;
            break;
         end
         @(negedge clk);
      end
      t_fall = -1;
      for (int i = 0; i < LIMIT; i++) begin
         if (req_out === 1'b0) begin
            t_fall = cyc;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (t_ack < 0 || t_fall != t_ack + S) begin
         errors++;
         $display("FAIL hs_req_fall: fell at %0d want %0d", t_fall, t_ack + S);
      end
      t_drop = -1;
      for (int i = 0; i < LIMIT; i++) begin
         if (ack_in === 1'b0) begin
            t_drop = cyc + 1;
            break;
         end
         @(negedge clk);
      end
      wait_done(t_done, ok);
      checks++;
      if (!ok || t_done != t_drop + S || busy !== 1'b0) begin
         errors++;
         $display("FAIL hs_done: done at %0d busy=%b want %0d busy=0", t_done, busy, t_drop + S);
      end
      checks++;
      if (t_done - t_send != 2 * RESP_DLY + 2 * S) begin
         errors++;
         $display("FAIL hs_length: %0d cycles want %0d", t_done - t_send, 2 * RESP_DLY + 2 * S);
      end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (data_out !== exp) begin
         errors++;
         $display("FAIL hs_payload: data_out=%h want %h", data_out, exp);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL hs_done_pulse: done=%b pulses=%0d want 0 and 1", done, done_cnt - d0);
      end
   endtask

   task automatic test_busy_ignore();
      int t, d0;
      bit ok;
      logic [WIDTH-1:0] exp;
      d0   = done_cnt;
      send = 1'b1;
      data = 8'hA5;
      exp_q.push_back(8'hA5);
      @(negedge clk);
      data = 8'h3C;
      repeat (3) @(negedge clk);
      checks++;
      if (data_out !== 8'hA5 || busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_ignore: data_out=%h busy=%b want a5 1", data_out, busy);
      end
      send = 1'b0;
      wait_done(t, ok);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (!ok || data_out !== exp) begin
         errors++;
         $display("FAIL busy_first_payload: done=%b data_out=%h want 1 %h", ok, data_out, exp);
      end
      @(negedge clk);
      checks++;
      if (done_cnt - d0 != 1 || data_out !== 8'hA5) begin
         errors++;
         $display("FAIL busy_hold: pulses=%0d data_out=%h want 1 a5", done_cnt - d0, data_out);
      end
      send = 1'b1;
      data = 8'h3C;
      exp_q.push_back(8'h3C);
      @(negedge clk);
      send = 1'b0;
      wait_done(t, ok);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (!ok || data_out !== exp) begin
         errors++;
         $display("FAIL busy_second_payload: done=%b data_out=%h want 1 %h", ok, data_out, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int t, d0, e0;
      bit ok;
      logic [WIDTH-1:0] exp;
      resp_en = 1'b0;
      send    = 1'b1;
      data    = 8'h11;
      @(negedge clk);
      send = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (req_out !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_req: req=%b busy=%b want 1 1", req_out, busy);
      end
      d0    = done_cnt;
      e0    = err_cnt;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({req_out, busy, done, err} !== 4'b0000 || data_out !== '0) begin
         errors++;
         $display("FAIL mid_reset: req/busy/done/err=%b data_out=%h want 0000 00",
                  {req_out, busy, done, err}, data_out);
      end
      reset = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (done_cnt != d0 || err_cnt != e0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_after: done+%0d err+%0d busy=%b want 0 0 0", done_cnt - d0, err_cnt - e0, busy);
      end
      resp_en = 1'b1;
      send    = 1'b1;
      data    = 8'h5A;
      exp_q.push_back(8'h5A);
      @(negedge clk);
      send = 1'b0;
      wait_done(t, ok);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (!ok || data_out !== exp) begin
         errors++;
         $display("FAIL mid_recover: done=%b data_out=%h want 1 %h", ok, data_out, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int t1, t2, d0;
      bit ok1, ok2;
      logic [WIDTH-1:0] exp;
      resp_en = 1'b1;
      d0      = done_cnt;
      send    = 1'b1;
      data    = 8'h81;
      exp_q.push_back(8'h81);
      exp_q.push_back(8'h82);
      @(negedge clk);
      data = 8'h82;
      wait_done(t1, ok1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (!ok1 || data_out !== exp) begin
         errors++;
         $display("FAIL b2b_first: done=%b data_out=%h want 1 %h", ok1, data_out, exp);
      end
      @(negedge clk);
      send = 1'b0;
      checks++;
      if (req_out !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || data_out !== 8'h82) begin
         errors++;
         $display("FAIL b2b_restart: req=%b busy=%b done=%b data_out=%h want 1 1 0 82",
                  req_out, busy, done, data_out);
      end
      wait_done(t2, ok2);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (!ok2 || data_out !== exp || t2 - t1 != 1 + 2 * RESP_DLY + 2 * S) begin
         errors++;
         $display("FAIL b2b_second: done=%b data_out=%h gap=%0d want 1 %h %0d",
                  ok2, data_out, t2 - t1, exp, 1 + 2 * RESP_DLY + 2 * S);
      end
      @(negedge clk);
      checks++;
      if (done_cnt - d0 != 2) begin
         errors++;
         $display("FAIL b2b_pulses: %0d want 2", done_cnt - d0);
      end
   endtask

   task automatic test_timeout();
      int d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
`ifdef HS_TIMEOUT_EN
      begin
         int t_entry, t_fall;
         resp_en = 1'b0;
         send    = 1'b1;
         data    = 8'hC3;
         @(negedge clk);
         send    = 1'b0;
         t_entry = cyc;
         t_fall  = -1;
         for (int i = 0; i < LIMIT; i++) begin
            if (req_out === 1'b0) begin
               t_fall = cyc;
               break;
            end
            @(negedge clk);
         end
         checks++;
         if (t_fall != t_entry + TMO || err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_expire: fell at %0d err=%b busy=%b want %0d 1 1",
                     t_fall, err, busy, t_entry + TMO);
         end
         @(negedge clk);
         checks++;
         if (err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL tmo_return: err=%b busy=%b done=%b want 0 0 0", err, busy, done);
         end
         repeat (3) @(negedge clk);
         checks++;
         if (done_cnt != d0 || err_cnt - e0 != 1) begin
            errors++;
            $display("FAIL tmo_counts: done+%0d err+%0d want 0 1", done_cnt - d0, err_cnt - e0);
         end
      end
`else
      begin
         int t;
         bit ok;
         logic [WIDTH-1:0] exp;
         resp_en = 1'b0;
         send    = 1'b1;
         data    = 8'hC3;
         exp_q.push_back(8'hC3);
         @(negedge clk);
         send = 1'b0;
         repeat (2 * TMO) @(negedge clk);
         checks++;
         if (req_out !== 1'b1 || busy !== 1'b1 || err_cnt != e0 || done_cnt != d0) begin
            errors++;
            $display("FAIL no_tmo_wait: req=%b busy=%b err+%0d done+%0d want 1 1 0 0",
                     req_out, busy, err_cnt - e0, done_cnt - d0);
         end
         resp_en = 1'b1;
         wait_done(t, ok);
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         checks++;
         if (!ok || data_out !== exp || err_cnt != e0) begin
            errors++;
            $display("FAIL no_tmo_finish: done=%b data_out=%h err+%0d want 1 %h 0",
                     ok, data_out, err_cnt - e0, exp);
         end
         @(negedge clk);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_handshake();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      test_timeout();
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/handshake_tx.md
# handshake_tx

Initiator (source) side of the single-bit-synchronized 4-phase req/ack handshake used for clock-domain crossings. It latches a WIDTH-bit word on a local `send` strobe and drives `req_out` with `data_out` held stable. It synchronizes the asynchronous `ack_in` through a SYNC_STAGES flop chain and sequences the full req-up/ack-up/req-down/ack-down cycle. It sits in the sending clock domain, facing the receiving domain's synchronizer-based responder.

## Interface
- WIDTH, 8, payload width in bits
- SYNC_STAGES, 2, flops in the `ack_in` synchronizer chain (≥2)
- TIMEOUT_CYCLES, 255, REQ-state cycle limit (used only with HS_TIMEOUT_EN)

- clk  in  1  sending-domain clock, all logic on posedge
- reset  in  1  synchronous, active-high
- data  in  WIDTH  word to transmit, sampled when `send` accepted
- send  in  1  start strobe, accepted only in IDLE
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle timeout pulse (tied 0 without HS_TIMEOUT_EN)
- req_out  out  1  request to receiving domain, registered
- data_out  out  WIDTH  payload to receiving domain, registered
- ack_in  in  1  acknowledge from receiving domain, asynchronous

## Operation
- Sync chain: `ack_in` passes through SYNC_STAGES flops; `ack_s` is the last flop's output. The FSM uses only `ack_s`.
- States: IDLE, REQ, RELEASE.
- IDLE: if `send` is high, `data_out` <= `data`, `req_out` <= 1, and the state goes to REQ. Otherwise nothing changes.
- REQ: when `ack_s` = 1, `req_out` <= 0 and the state goes to RELEASE.
- RELEASE: when `ack_s` = 0, the state goes to IDLE and `done` <= 1 for one cycle. If the transaction timed out, `done` stays 0.
- `send` is ignored while `busy` is high. There is no queuing.
- `data_out` holds its value from acceptance until the next accepted `send`, including after `done`.
- If `ack_s` is already 1 on entering REQ (stale ack), the FSM still waits in REQ only for `ack_s` = 1. It then proceeds normally: RELEASE waits for the ack to fall.
- Reset values: state IDLE, `req_out` 0, `data_out` 0, `busy` 0, `done` 0, `err` 0, sync flops 0, timeout counter 0.
- Reset mid-transaction: `req_out` drops on that edge and any pending `done`/`err` is cancelled.

## Timing
- `send` sampled high at edge N: `req_out` and `busy` are high after edge N.
- `ack_in` rises before edge M: `ack_s` is high after edge M+SYNC_STAGES-1, and `req_out` falls after edge M+SYNC_STAGES.
- `ack_in` falls before edge K: `done` is high and `busy` is low after edge K+SYNC_STAGES, for exactly one cycle.
- Minimum transaction length, from `send` to `done`, is 2·SYNC_STAGES+2 cycles.
- Back-to-back: `send` asserted in the same cycle that `done` is high is accepted, because the state is already IDLE.

## Configuration
- HS_TIMEOUT_EN defined:
  - A counter clears on entry to REQ and increments each cycle in REQ.
  - If `ack_s` is still 0 when the count reaches TIMEOUT_CYCLES-1, the next edge drops `req_out`, pulses `err` for one cycle, and moves to RELEASE with a timed-out flag set.
  - RELEASE then returns to IDLE when `ack_s` = 0, without `done`.
  - If `ack_s` = 1 arrives on the same edge as expiry, the ack wins and no `err` is raised.
- HS_TIMEOUT_EN undefined: there is no counter. REQ waits indefinitely and `err` is constant 0.

## Test plan
- Reset then idle: all outputs 0. `send` = 1, `data` = 0xA5 → next cycle `req_out` = 1, `data_out` = 0xA5, `busy` = 1.
- Full handshake, SYNC_STAGES = 2: a responder model raises `ack_in` 3 cycles after `req_out` and drops it 3 cycles after `req_out` falls. Check: `req_out` falls 2 edges after the ack is sampled, `done` pulses once, and the total time matches Timing.
- `send` with `data` = 0x3C while busy → ignored. `data_out` stays 0xA5, and the next accepted `send` with 0x3C transmits 0x3C.
- Reset asserted in REQ with `ack_in` low → `req_out` = 0, `busy` = 0, no `done` or `err`. The next `send` completes normally.
- Back-to-back: `send` held high continuously → a second transaction starts the cycle `done` pulses. Two `done` pulses, no gap in acceptance.
- HS_TIMEOUT_EN with TIMEOUT_CYCLES = 16 and `ack_in` held 0 → `req_out` falls and `err` pulses 16 cycles after REQ entry. The FSM returns to IDLE and `done` stays 0.
